// File: rtl/riscv_pkg.sv
// Shared types and widths for the RISC-V fetch front end.
package riscv_pkg;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned ILEN       = 32;
   localparam int unsigned INST_BYTES = 4;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and a synchronous flush.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = count_q;
   assign rd_data = mem[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CW'(1);
         else if (!do_push && do_pop) count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: one-outstanding memory requester feeding a
// PC-tagged prefetch FIFO, flushed by execute-stage redirects.
module riscv_fetch_unit #(
   parameter int unsigned    XLEN     = riscv_pkg::XLEN,
   parameter int unsigned    ILEN     = riscv_pkg::ILEN,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [XLEN-1:0]            imem_req_addr,
   input  logic                       imem_rsp_valid,
   input  logic [ILEN-1:0]            imem_rsp_data,
   output logic                       inst_valid,
   input  logic                       inst_ready,
   output logic [ILEN-1:0]            inst_data,
   output logic [XLEN-1:0]            inst_pc,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   import riscv_pkg::*;

   localparam int unsigned EW = XLEN + ILEN;

   fetch_state_t    state_q;
   fetch_state_t    state_d;
   logic [XLEN-1:0] fetch_pc_q;
   logic [XLEN-1:0] fetch_pc_d;
   logic [XLEN-1:0] req_pc_q;
   logic [XLEN-1:0] req_pc_d;
   logic            req_fire;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [EW-1:0]   head;

   // Request is withdrawn during a redirect cycle and held low in reset.
   assign imem_req_valid = reset & (state_q == REQ) & ~fifo_full & ~redirect_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign inst_valid = ~fifo_empty;
   assign inst_pc    = head[EW-1:ILEN];
   assign inst_data  = head[ILEN-1:0];
   assign pop        = ~fifo_empty & inst_ready & ~redirect_valid;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      push       = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         // An in-flight request must still be absorbed before refetching.
         if (state_q == WAIT || state_q == DRAIN)
            state_d = imem_rsp_valid ? REQ : DRAIN;
      end else begin
         case (state_q)
            REQ: begin
               if (req_fire) begin
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
                  state_d    = WAIT;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  push    = 1'b1;
                  state_d = REQ;
               end
            end
            DRAIN: begin
               if (imem_rsp_valid) state_d = REQ;
            end
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= REQ;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (push),
      .push_data ({req_pc_q, imem_rsp_data}),
      .pop       (pop),
      .flush     (redirect_valid),
      .rd_data   (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation RISC-V core. It replaces the single-cycle PC register, PC+4 adder and direct instruction-memory read with a small FSM. It talks to a valid/ready instruction memory that has variable latency and at most one outstanding request. Fetched instructions are buffered in a prefetch FIFO, tagged with their PC, and delivered to decode over a valid/ready port. Branch and jump redirects from execute flush the FIFO and any in-flight response.

Parameters:
XLEN, 64, address/PC width in bits
ILEN, 32, instruction width in bits
DEPTH, 4, prefetch FIFO entries; power of two, at least 2
RESET_PC, 0, PC fetched first after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address; bits [1:0] always 0
imem_rsp_valid  in  1  response data valid; one cycle per accepted request
imem_rsp_data  in  ILEN  fetched instruction
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decode consumes head
inst_data  out  ILEN  head instruction
inst_pc  out  XLEN  PC of head instruction
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0
fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC, state=REQ, FIFO empty, fifo_count=0.
  - inst_valid=0, imem_req_valid=0 while reset is asserted.
- imem_req_valid = (state==REQ) & (fifo_count<DEPTH) & !redirect_valid.
- imem_req_addr = fetch_pc.
- First cycle after reset release: imem_req_valid=1, addr=RESET_PC.
- FSM states:
  - REQ:
    - If imem_req_valid & imem_req_ready: capture req_pc=fetch_pc, fetch_pc += 4 (mod 2^XLEN, wraps), go to WAIT.
    - imem_rsp_valid is ignored in REQ.
  - WAIT:
    - If imem_rsp_valid: push {req_pc, imem_rsp_data}, go to REQ.
  - DRAIN:
    - A redirect hit an in-flight request.
    - If imem_rsp_valid: discard the data, go to REQ.
- Memory contract:
  - Response arrives at least 1 cycle after acceptance.
  - In REQ, imem_req_valid stays asserted until accepted. The only exception is a redirect cycle; memory must tolerate withdrawal then.
- Redirect (highest priority, any state):
  - FIFO flushed, fifo_count=0 next cycle.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - REQ: stay in REQ; the request issues the cycle after redirect.
  - WAIT with no imem_rsp_valid that cycle: go to DRAIN.
  - WAIT with imem_rsp_valid the same cycle: drop the response, go to REQ.
  - DRAIN without response: stay in DRAIN, fetch_pc updated. With response: drop it, go to REQ.
  - A pop in the same cycle as a redirect is treated as consumed; no error.
- FIFO:
  - inst_valid = fifo_count!=0; inst_data and inst_pc come from the head entry.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle: count unchanged, ordering preserved.
  - Push never occurs when full: a request issues only if fifo_count<DEPTH, and only one is outstanding.
  - Latency: response at cycle t gives inst_valid at t+1 (FIFO is empty-bypass free, registered).
- Throughput:
  - 1 instruction per 2 cycles with zero-wait memory (request, then response).
  - inst_ready=0 stalls fetching once the FIFO is full; it never drops data.
- Reset asserted mid-WAIT: immediately return to the reset state. A late response after release arrives in REQ and is ignored.

Decomposition:
- riscv_pkg holds:
  - XLEN/ILEN defaults
  - INST_BYTES=4
  - fetch_state_t enum {REQ, WAIT, DRAIN}
  - fetch_entry_t struct {pc, inst}
- Sub-module sync_fifo: parametrised WIDTH/DEPTH, push/pop/flush, count/full/empty, same reset. riscv_fetch_unit instantiates it with WIDTH=XLEN+ILEN.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, then release -> imem_req_valid=1, addr=0x0 on the first cycle; inst_valid=0; fifo_count=0.
2. Zero-wait stream: memory returns 0x00000013 (nop) one cycle after each accept, inst_ready=1 -> inst_pc 0x0, 0x4, 0x8, 0xC, one every 2 cycles, each inst_data=0x00000013.
3. Backpressure: DEPTH=4, inst_ready=0 -> after 4 responses fifo_count=4 and imem_req_valid=0; one pop -> next request addr=0x10 and order preserved.
4. Redirect in WAIT: redirect_pc=0x100 one cycle before the response -> response dropped, fifo_count=0, next request addr=0x100, next inst_pc=0x100.
5. Redirect same cycle as imem_rsp_valid, redirect_pc=0x102 -> data dropped, state REQ, next request addr=0x100 (low bits forced to 0).
6. Wrap and async reset: RESET_PC=2^64-4 -> second request addr=0x0. Then assert reset mid-WAIT -> imem_req_valid=0 and inst_valid=0 with no clock edge; a stale imem_rsp_valid after release is ignored.
